// File: rtl/ttt_pkg.sv
// ttt_pkg: encodings, sizes and FSM states shared by the tic-tac-toe tile,
// line checker and move controller.
package ttt_pkg;
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] X = 2'd1;
    localparam logic [1:0] O = 2'd2;
    localparam int NUM_TILES = 9;
    localparam logic [3:0] CURSOR_RESET = 4'd4;
    typedef enum logic [1:0] {PLAY, COMMIT, SETTLE, DONE} state_t;
endpackage

// File: rtl/ttt_cursor.sv
// ttt_cursor: next cursor on the 3x3 grid; up/down wrap within the column,
// left/right wrap within the row, priority up > down > left > right.
module ttt_cursor (
    input  logic [3:0] cur_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [3:0] cur_o
);
    logic row0, row2, col0, col2;
    always_comb begin
        row0  = cur_i < 4'd3;
        row2  = cur_i >= 4'd6;
        col0  = cur_i == 4'd0 || cur_i == 4'd3 || cur_i == 4'd6;
        col2  = cur_i == 4'd2 || cur_i == 4'd5 || cur_i == 4'd8;
        cur_o = up_i    ? (row0 ? cur_i + 4'd6 : cur_i - 4'd3) :
                down_i  ? (row2 ? cur_i - 4'd6 : cur_i + 4'd3) :
                left_i  ? (col0 ? cur_i + 4'd2 : cur_i - 4'd1) :
                right_i ? (col2 ? cur_i - 4'd2 : cur_i + 4'd1) : cur_i;
    end
endmodule

// File: rtl/move_ctrl.sv
// move_ctrl: turns button pulses into cursor moves and one-cycle tile selects,
// tracks turn and move count, and ends the game on a win or a full board.
module move_ctrl
    import ttt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_up,
    input  logic                 btn_down,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic                 btn_place,
    input  logic [17:0]          board,
    input  logic [1:0]           winner,
    output logic [NUM_TILES-1:0] sel,
    output logic                 turn,
    output logic [3:0]           cursor,
    output logic [3:0]           move_count,
    output logic                 game_over,
    output logic                 draw,
    output logic                 illegal
);
    state_t state_q, state_d;
    logic [NUM_TILES-1:0] sel_q, sel_d;
    logic [3:0] cursor_q, cursor_d, cnt_q, cnt_d, cur_nav, cnt_inc;
    logic turn_q, turn_d, over_q, over_d, draw_q, draw_d, ill_q, ill_d;
    logic [1:0] tile;

    ttt_cursor u_cursor (
        .cur_i   (cursor_q),
        .up_i    (btn_up),
        .down_i  (btn_down),
        .left_i  (btn_left),
        .right_i (btn_right),
        .cur_o   (cur_nav)
    );

    assign tile    = board[{cursor_q, 1'b0} +: 2];
    assign cnt_inc = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        turn_d   = turn_q;
        sel_d    = '0;
        cnt_d    = cnt_q;
        over_d   = over_q;
        draw_d   = draw_q;
        ill_d    = 1'b0;
        case (state_q)
            PLAY: begin
                if (btn_place && tile == EMPTY) begin
                    sel_d   = NUM_TILES'(1) << cursor_q;
                    state_d = COMMIT;
                end else if (btn_place) begin
                    ill_d = 1'b1;
                end else begin
                    cursor_d = cur_nav;
                end
            end
            COMMIT: state_d = SETTLE;
            SETTLE: begin
                // winner is only trusted here, once the board shows the new move
                cnt_d = cnt_inc;
                if (winner != EMPTY || cnt_inc == 4'd9) begin
                    state_d = DONE;
                    over_d  = 1'b1;
                    draw_d  = winner == EMPTY;
                end else begin
                    turn_d  = ~turn_q;
                    state_d = PLAY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            cursor_q <= CURSOR_RESET;
            turn_q   <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            over_q   <= 1'b0;
            draw_q   <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            turn_q   <= turn_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            over_q   <= over_d;
            draw_q   <= draw_d;
            ill_q    <= ill_d;
        end
    end

    assign sel        = sel_q;
    assign turn       = turn_q;
    assign cursor     = cursor_q;
    assign move_count = cnt_q;
    assign game_over  = over_q;
    assign draw       = draw_q;
    assign illegal    = ill_q;
endmodule
